// File: rtl/sha256_pkg.sv
// Shared SHA-256 datapath types: word type, block geometry, message-load FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  // Width of a word index within one 512-bit block.
  localparam int IDX_W       = 4;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } msg_load_state_t;

endpackage

// File: rtl/msg_rd_tracker.sv
// Tracks fixed-latency memory reads: a READ_LATENCY-deep valid/index shift register.
// Latency: a push appears on rsp_valid exactly READ_LATENCY cycles later.
// Backpressure: none; the memory cannot stall, so every push pops on schedule.
module msg_rd_tracker
  import sha256_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [IDX_W-1:0] push_index,
  output logic             rsp_valid,
  output logic [IDX_W-1:0] rsp_index,
  output logic             inflight
);

  logic [READ_LATENCY-1:0] vld_q;
  logic [IDX_W-1:0]        idx_q [READ_LATENCY];

  // Shift the read tags along one stage per cycle; reset drops every outstanding read.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= push;
      idx_q[0] <= push_index;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  // The oldest stage lines up with the cycle the memory data is valid.
  always_comb begin
    rsp_valid = vld_q[READ_LATENCY-1];
    rsp_index = idx_q[READ_LATENCY-1];
    inflight  = |vld_q;
  end

endmodule

// File: rtl/msg_word_loader.sv
// Fetches one 512-bit message block as NUM_WORDS words from a read-only memory and streams them out in order.
// Latency: enable sampled -> done = NUM_WORDS + READ_LATENCY + 2 cycles; first word 2 + READ_LATENCY cycles after start.
// Backpressure: none downstream; enables while busy are ignored and a held enable must drop before re-arming.
// Build option: define MSG_LOAD_BYTE_SWAP_EN to byte-reverse each word (little-endian message memory).
module msg_word_loader #(
  parameter int WORD_W       = 32,
  parameter int NUM_WORDS    = 16,
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              word_valid,
  output logic [3:0]        word_index,
  output logic [WORD_W-1:0] word_data,
  output logic              busy,
  output logic              done
);

  import sha256_pkg::*;

  msg_load_state_t   state_q;
  msg_load_state_t   state_d;
  logic              armed_q;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  issue_cnt_q;
  logic              start;
  logic              last_issue;
  logic              rsp_valid;
  logic [IDX_W-1:0]  rsp_index;
  logic              inflight;
  logic [WORD_W-1:0] cap_data;

  assign start      = (state_q == IDLE) && enable && armed_q;
  assign last_issue = (state_q == ISSUE) && (issue_cnt_q == IDX_W'(NUM_WORDS - 1));

`ifdef MSG_LOAD_BYTE_SWAP_EN
  assign cap_data = {<<8{mem_rd_data}};
`else
  assign cap_data = mem_rd_data;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: issue NUM_WORDS reads, drain the read pipe, then one FIN cycle for done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)      state_d = ISSUE;
      ISSUE:   if (last_issue) state_d = DRAIN;
      DRAIN:   if (!inflight)  state_d = FIN;
      FIN:                     state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; the address is forced to zero outside ISSUE.
  always_comb begin
    mem_rd_en = (state_q == ISSUE);
    mem_addr  = '0;
    if (state_q == ISSUE) begin
      mem_addr = base_q + ADDR_W'(issue_cnt_q);
    end
    busy = (state_q != IDLE);
    done = (state_q == FIN);
  end

  // Re-arm on any low enable; latch the base and restart the issue count on a start.
  always_ff @(posedge clock) begin
    if (reset) begin
      armed_q     <= 1'b1;
      base_q      <= '0;
      issue_cnt_q <= '0;
    end else begin
      if (!enable) begin
        armed_q <= 1'b1;
      end else if (start) begin
        armed_q <= 1'b0;
      end
      if (start) begin
        base_q      <= base_addr;
        issue_cnt_q <= '0;
      end else if (state_q == ISSUE) begin
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end
    end
  end

  msg_rd_tracker #(
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_tracker (
    .clock      (clock),
    .reset      (reset),
    .push       (mem_rd_en),
    .push_index (issue_cnt_q),
    .rsp_valid  (rsp_valid),
    .rsp_index  (rsp_index),
    .inflight   (inflight)
  );

  // Capture returning data one cycle after it is valid; word_data holds between words.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_valid <= 1'b0;
      word_index <= '0;
      word_data  <= '0;
    end else begin
      word_valid <= rsp_valid;
      if (rsp_valid) begin
        word_index <= rsp_index;
        word_data  <= cap_data;
      end
    end
  end

endmodule

// File: tb/tb_msg_word_loader.sv
// Directed bench for msg_word_loader: one instance at READ_LATENCY=1, one at READ_LATENCY=3, shared stimulus.
// Memory model: word at address a is a*0x01010101 (32-bit), returned READ_LATENCY cycles after the strobe.
// Cycle n below means the cycle after the n-th rising edge, where edge 0 samples enable high.
module tb_msg_word_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] base_addr;

  logic        mem_rd_en,   mem_rd_en_3;
  logic [15:0] mem_addr,    mem_addr_3;
  logic [31:0] mem_rd_data, mem_rd_data_3;
  logic        word_valid,  word_valid_3;
  logic [3:0]  word_index,  word_index_3;
  logic [31:0] word_data,   word_data_3;
  logic        busy,        busy_3;
  logic        done,        done_3;

  logic [31:0] p1, p2, p3;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  msg_word_loader #(.READ_LATENCY(1)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .base_addr   (base_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .word_valid  (word_valid),
    .word_index  (word_index),
    .word_data   (word_data),
    .busy        (busy),
    .done        (done)
  );

  msg_word_loader #(.READ_LATENCY(3)) u_dut_3 (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .base_addr   (base_addr),
    .mem_rd_en   (mem_rd_en_3),
    .mem_addr    (mem_addr_3),
    .mem_rd_data (mem_rd_data_3),
    .word_valid  (word_valid_3),
    .word_index  (word_index_3),
    .word_data   (word_data_3),
    .busy        (busy_3),
    .done        (done_3)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [31:0] w;
    w = {16'h0000, a};
    return w * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] exp_word(input logic [15:0] a);
    logic [31:0] w;
    w = mem_word(a);
`ifdef MSG_LOAD_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Latency-1 memory.
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= mem_word(mem_addr);
  end

  // Latency-3 memory.
  always @(posedge clock) begin
    p1 <= mem_word(mem_addr_3);
    p2 <= p1;
    p3 <= p2;
  end
  assign mem_rd_data_3 = p3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},  mem_rd_en,  0);
    check({tag, "_addr"},   mem_addr,   0);
    check({tag, "_wvld"},   word_valid, 0);
    check({tag, "_widx"},   word_index, 0);
    check({tag, "_wdat"},   word_data,  0);
    check({tag, "_busy"},   busy,       0);
    check({tag, "_done"},   done,       0);
    check({tag, "_wvld3"},  word_valid_3, 0);
    check({tag, "_busy3"},  busy_3,     0);
    check({tag, "_done3"},  done_3,     0);
  endtask

  // mode 0: one-cycle enable pulse; mode 1: enable held 40 cycles; mode 2: enable toggled in cycles 5..10.
  task automatic run_load(input logic [15:0] base, input int mode);
    logic [15:0] ea;
    int ncyc;
    ncyc = (mode == 1) ? 42 : 24;
    @(negedge clock);
    check("idle_busy", busy, 0);
    enable    = 1'b1;
    base_addr = base;
    @(posedge clock);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clock);
      check("rd_en", mem_rd_en, (n >= 1 && n <= 16));
      if (n <= 16) begin
        ea = base + 16'(n - 1);
        check("addr", mem_addr, ea);
      end
      check("word_valid", word_valid, (n >= 3 && n <= 18));
      if (n >= 3 && n <= 18) begin
        ea = base + 16'(n - 3);
        check("word_index", word_index, n - 3);
        check("word_data", word_data, exp_word(ea));
      end else if (n > 18) begin
        ea = base + 16'd15;
        check("word_hold", word_data, exp_word(ea));
      end
      check("done", done, (n == 19));
      check("busy", busy, (n <= 19));
      check("word_valid3", word_valid_3, (n >= 5 && n <= 20));
      if (n >= 5 && n <= 20) begin
        ea = base + 16'(n - 5);
        check("word_index3", word_index_3, n - 5);
        check("word_data3", word_data_3, exp_word(ea));
      end
      check("done3", done_3, (n == 21));
      check("busy3", busy_3, (n <= 21));
      case (mode)
        0:       enable = 1'b0;
        1:       enable = (n < 40);
        default: enable = (n >= 5 && n <= 10) ? (n % 2 == 1) : 1'b0;
      endcase
    end
    enable = 1'b0;
  endtask

  // Reset lands on edge 8 of a load; afterwards nothing may come out.
  task automatic run_reset_mid(input logic [15:0] base);
    @(negedge clock);
    enable    = 1'b1;
    base_addr = base;
    @(posedge clock);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (n == 7) check("pre_rst_busy", busy, 1);
      if (n == 8) check_all_zero("mid_rst");
      if (n > 8) begin
        check("post_rst_rd_en", mem_rd_en, 0);
        check("post_rst_wvld",  word_valid, 0);
        check("post_rst_done",  done, 0);
        check("post_rst_done3", done_3, 0);
      end
      enable = 1'b0;
      reset  = (n == 7);
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    base_addr = 16'h0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;

    run_load(16'h0100, 0);
    run_load(16'h0200, 1);
    run_load(16'h0500, 2);
    run_load(16'hFFF8, 0);
    run_reset_mid(16'h0300);
    run_load(16'h0400, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
